ddr_arbiter: RTL and testbench

Two-requester arbiter sharing the single DDR cacheline port between the instruction and data `l1cache` instances. It sits between both L1 caches' DDR-side interfaces and the DDR controller. The arbiter serializes cacheline read and write transactions, routes each response only to the owning cache, and guarantees the instruction side cannot be starved.

---
 rtl/rvga_types.sv | 27 ++
 rtl/ddr_arbiter_pick.sv | 72 +++++++
 rtl/ddr_arbiter.sv | 127 ++++++++++++
 tb/tb_ddr_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rvga_types.sv
// Shared RVGA types: word/cacheline widths and the DDR arbiter's state and
// owner encodings.
package rvga_types;

    typedef logic [31:0]  rvga_word;
    typedef logic [255:0] rvga_cacheline;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } rvga_arb_state_t;

    typedef enum logic {
        ARB_OWN_I = 1'b0,
        ARB_OWN_D = 1'b1
    } rvga_arb_owner_t;

    // Width of the starvation counter; enough for a limit of up to 15.
    localparam int unsigned ARB_CNT_W = 4;

    // A cache is requesting when either of its strobes is high.
    function automatic logic arb_has_req(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/ddr_arbiter_pick.sv
// ddr_arbiter_pick: combinational arbitration policy for ddr_arbiter.
// Default build: fixed priority (D-cache wins ties) with a starvation
// counter that forces an I-cache grant after starve_limit D-cache wins.
// With DDR_ARB_RR_EN defined: round-robin on ties using the last owner;
// the counter output is then tied to zero.
import rvga_types::*;

module ddr_arbiter_pick #(
    parameter int unsigned starve_limit = 4
) (
    input  logic                 icache_req_i,
    input  logic                 dcache_req_i,
    input  logic [ARB_CNT_W-1:0] starve_cnt_i,
    input  rvga_arb_owner_t      last_owner_i,
    output logic                 grant_o,
    output rvga_arb_owner_t      owner_o,
    output logic [ARB_CNT_W-1:0] starve_cnt_o
);

    localparam logic [ARB_CNT_W-1:0] LIMIT = ARB_CNT_W'(starve_limit);

`ifdef DDR_ARB_RR_EN
    // The counter and its limit have no role under round-robin.
    logic unused_cnt_s;
    assign unused_cnt_s = ^{starve_cnt_i, LIMIT};

    // Round-robin: on a tie the side that did not win last time goes next.
    always_comb begin
        grant_o      = icache_req_i | dcache_req_i;
        owner_o      = ARB_OWN_I;
        starve_cnt_o = {ARB_CNT_W{1'b0}};
        if (icache_req_i && dcache_req_i) begin
            owner_o = (last_owner_i == ARB_OWN_I) ? ARB_OWN_D : ARB_OWN_I;
        end else if (dcache_req_i) begin
            owner_o = ARB_OWN_D;
        end else begin
            owner_o = ARB_OWN_I;
        end
    end
`else
    // Last owner only matters under round-robin.
    logic unused_last_s;
    assign unused_last_s = last_owner_i;

    // Fixed priority: D-cache wins ties until the I-cache has waited through
    // starve_limit D-cache grants; any other grant restarts the count.
    always_comb begin
        grant_o      = icache_req_i | dcache_req_i;
        owner_o      = ARB_OWN_I;
        starve_cnt_o = starve_cnt_i;
        if (icache_req_i && dcache_req_i) begin
            if (starve_cnt_i >= LIMIT) begin
                owner_o      = ARB_OWN_I;
                starve_cnt_o = {ARB_CNT_W{1'b0}};
            end else begin
                owner_o      = ARB_OWN_D;
                starve_cnt_o = starve_cnt_i + {{(ARB_CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (dcache_req_i) begin
            owner_o      = ARB_OWN_D;
            starve_cnt_o = {ARB_CNT_W{1'b0}};
        end else if (icache_req_i) begin
            owner_o      = ARB_OWN_I;
            starve_cnt_o = {ARB_CNT_W{1'b0}};
        end else begin
            owner_o      = ARB_OWN_I;
            starve_cnt_o = starve_cnt_i;
        end
    end
`endif

endmodule

// File: rtl/ddr_arbiter.sv
// ddr_arbiter: shares the single DDR cacheline port between the I-cache and
// D-cache. One transaction at a time; the owner's request is passed straight
// through and the DDR response is routed back to the owner only. Every
// response is followed by one IDLE cycle in which arbitration reruns.
// Policy selection: define DDR_ARB_RR_EN for round-robin (see ddr_arbiter_pick).
import rvga_types::*;

module ddr_arbiter #(
    parameter int unsigned starve_limit = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  rvga_word      icache_arb_addr,
    input  logic          icache_arb_read,
    input  logic          icache_arb_write,
    input  rvga_cacheline icache_arb_wdata,
    output rvga_cacheline arb_icache_rdata,
    output logic          arb_icache_resp,
    input  rvga_word      dcache_arb_addr,
    input  logic          dcache_arb_read,
    input  logic          dcache_arb_write,
    input  rvga_cacheline dcache_arb_wdata,
    output rvga_cacheline arb_dcache_rdata,
    output logic          arb_dcache_resp,
    output rvga_word      arb_ddr_addr,
    output logic          arb_ddr_read,
    output logic          arb_ddr_write,
    output rvga_cacheline arb_ddr_wdata,
    input  rvga_cacheline ddr_arb_rdata,
    input  logic          ddr_arb_resp
);

    rvga_arb_state_t      state_q, state_d;
    logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
    rvga_arb_owner_t      last_q, last_d;

    logic                 grant_s;
    rvga_arb_owner_t      owner_s;
    logic [ARB_CNT_W-1:0] pick_cnt_s;

    ddr_arbiter_pick #(
        .starve_limit (starve_limit)
    ) u_pick (
        .icache_req_i (arb_has_req(icache_arb_read, icache_arb_write)),
        .dcache_req_i (arb_has_req(dcache_arb_read, dcache_arb_write)),
        .starve_cnt_i (cnt_q),
        .last_owner_i (last_q),
        .grant_o      (grant_s),
        .owner_o      (owner_s),
        .starve_cnt_o (pick_cnt_s)
    );

    // Read data is broadcast; only the owner's resp makes it meaningful.
    assign arb_icache_rdata = ddr_arb_rdata;
    assign arb_dcache_rdata = ddr_arb_rdata;

    // Next state: grant from IDLE, release back to IDLE on the DDR response.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_s) begin
                    state_d = (owner_s == ARB_OWN_I) ? ARB_GNT_I : ARB_GNT_D;
                    cnt_d   = pick_cnt_s;
                    last_d  = owner_s;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GNT_I, ARB_GNT_D: begin
                if (ddr_arb_resp) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Pass the owner's request to DDR and route the response back to it.
    always_comb begin
        arb_ddr_addr    = 32'h0000_0000;
        arb_ddr_read    = 1'b0;
        arb_ddr_write   = 1'b0;
        arb_ddr_wdata   = {256{1'b0}};
        arb_icache_resp = 1'b0;
        arb_dcache_resp = 1'b0;
        case (state_q)
            ARB_GNT_I: begin
                arb_ddr_addr    = icache_arb_addr;
                arb_ddr_read    = icache_arb_read;
                arb_ddr_write   = icache_arb_write;
                arb_ddr_wdata   = icache_arb_wdata;
                arb_icache_resp = ddr_arb_resp;
            end
            ARB_GNT_D: begin
                arb_ddr_addr    = dcache_arb_addr;
                arb_ddr_read    = dcache_arb_read;
                arb_ddr_write   = dcache_arb_write;
                arb_ddr_wdata   = dcache_arb_wdata;
                arb_dcache_resp = ddr_arb_resp;
            end
            default: begin
                arb_ddr_addr    = 32'h0000_0000;
            end
        endcase
    end

    // State, starvation counter and last-owner registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            cnt_q   <= {ARB_CNT_W{1'b0}};
            last_q  <= ARB_OWN_I;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed, table-driven bench for ddr_arbiter. Each table row is one clock
// cycle: inputs driven on the falling edge, outputs compared 1 ns later.
// Rows marked with a DDR response also check the routed resp and rdata.
module tb_ddr_arbiter;

    localparam logic [31:0]  I_ADDR  = 32'h0000_1000;
    localparam logic [31:0]  D_ADDR  = 32'h0000_2040;
    localparam logic [255:0] I_WDATA = {8{32'hCAFE_0001}};
    localparam logic [255:0] D_WDATA = {8{32'h1234_5678}};
    localparam logic [255:0] RDATA   = {32{8'hA5}};

    logic         clk;
    logic         rst;
    logic [31:0]  icache_arb_addr;
    logic         icache_arb_read;
    logic         icache_arb_write;
    logic [255:0] icache_arb_wdata;
    logic [255:0] arb_icache_rdata;
    logic         arb_icache_resp;
    logic [31:0]  dcache_arb_addr;
    logic         dcache_arb_read;
    logic         dcache_arb_write;
    logic [255:0] dcache_arb_wdata;
    logic [255:0] arb_dcache_rdata;
    logic         arb_dcache_resp;
    logic [31:0]  arb_ddr_addr;
    logic         arb_ddr_read;
    logic         arb_ddr_write;
    logic [255:0] arb_ddr_wdata;
    logic [255:0] ddr_arb_rdata;
    logic         ddr_arb_resp;

    ddr_arbiter #(.starve_limit(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .icache_arb_addr  (icache_arb_addr),
        .icache_arb_read  (icache_arb_read),
        .icache_arb_write (icache_arb_write),
        .icache_arb_wdata (icache_arb_wdata),
        .arb_icache_rdata (arb_icache_rdata),
        .arb_icache_resp  (arb_icache_resp),
        .dcache_arb_addr  (dcache_arb_addr),
        .dcache_arb_read  (dcache_arb_read),
        .dcache_arb_write (dcache_arb_write),
        .dcache_arb_wdata (dcache_arb_wdata),
        .arb_dcache_rdata (arb_dcache_rdata),
        .arb_dcache_resp  (arb_dcache_resp),
        .arb_ddr_addr     (arb_ddr_addr),
        .arb_ddr_read     (arb_ddr_read),
        .arb_ddr_write    (arb_ddr_write),
        .arb_ddr_wdata    (arb_ddr_wdata),
        .ddr_arb_rdata    (ddr_arb_rdata),
        .ddr_arb_resp     (ddr_arb_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // own: 0 = no owner (all DDR outputs zero), 1 = I-cache, 2 = D-cache
    typedef struct {
        logic       rst;
        logic       ir, iw, dr, dw, resp;
        logic [1:0] own;
        logic       e_rd, e_wr, e_irsp, e_drsp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic r, input logic ir, input logic iw,
                                input logic dr, input logic dw, input logic rsp,
                                input logic [1:0] own, input logic e_rd,
                                input logic e_wr, input logic e_irsp,
                                input logic e_drsp);
        vec_t v;
        v.rst = r; v.ir = ir; v.iw = iw; v.dr = dr; v.dw = dw; v.resp = rsp;
        v.own = own; v.e_rd = e_rd; v.e_wr = e_wr;
        v.e_irsp = e_irsp; v.e_drsp = e_drsp;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_row(input vec_t v, input int idx);
        logic [31:0]  e_addr;
        logic [255:0] e_wdata;
        e_addr  = 32'h0000_0000;
        e_wdata = {256{1'b0}};
        if (v.own == 2'd1) begin
            e_addr = I_ADDR; e_wdata = I_WDATA;
        end else if (v.own == 2'd2) begin
            e_addr = D_ADDR; e_wdata = D_WDATA;
        end
        chk("ddr_addr",  idx, {224'd0, arb_ddr_addr}, {224'd0, e_addr});
        chk("ddr_read",  idx, {255'd0, arb_ddr_read},  {255'd0, v.e_rd});
        chk("ddr_write", idx, {255'd0, arb_ddr_write}, {255'd0, v.e_wr});
        chk("ddr_wdata", idx, arb_ddr_wdata, e_wdata);
        chk("i_resp",    idx, {255'd0, arb_icache_resp}, {255'd0, v.e_irsp});
        chk("d_resp",    idx, {255'd0, arb_dcache_resp}, {255'd0, v.e_drsp});
        if (v.e_irsp) chk("i_rdata", idx, arb_icache_rdata, RDATA);
        if (v.e_drsp) chk("d_rdata", idx, arb_dcache_rdata, RDATA);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic found;

        // Reset state
        vecs.push_back(mk(1,0,0,0,0,0, 2'd0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,1, 2'd0, 0,0,0,0));
        // I-cache read alone, DDR responds 3 cycles after the strobe
        vecs.push_back(mk(0,1,0,0,0,0, 2'd0, 0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 2'd1, 1,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 2'd1, 1,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 2'd1, 1,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,1, 2'd1, 1,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 2'd0, 0,0,0,0));
`ifdef DDR_ARB_RR_EN
        // Both sides request continuously: D, I, D, I, D, I
        for (int t = 0; t < 6; t++) begin
            vecs.push_back(mk(0,1,0,1,0,0, 2'd0, 0,0,0,0));
            if (t % 2 == 0)
                vecs.push_back(mk(0,1,0,1,0,1, 2'd2, 1,0,0,1));
            else
                vecs.push_back(mk(0,1,0,1,0,1, 2'd1, 1,0,1,0));
        end
        vecs.push_back(mk(0,0,0,0,0,0, 2'd0, 0,0,0,0));
`else
        // Simultaneous reads: D first, I granted in the bubble after D's resp
        vecs.push_back(mk(0,1,0,1,0,0, 2'd0, 0,0,0,0));
        vecs.push_back(mk(0,1,0,1,0,0, 2'd2, 1,0,0,0));
        vecs.push_back(mk(0,1,0,1,0,1, 2'd2, 1,0,0,1));
        vecs.push_back(mk(0,1,0,0,0,0, 2'd0, 0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 2'd1, 1,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,1, 2'd1, 1,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 2'd0, 0,0,0,0));
        // Starvation: four D grants while I waits, fifth grant goes to I
        for (int t = 0; t < 4; t++) begin
            vecs.push_back(mk(0,1,0,1,0,0, 2'd0, 0,0,0,0));
            vecs.push_back(mk(0,1,0,1,0,1, 2'd2, 1,0,0,1));
        end
        vecs.push_back(mk(0,1,0,1,0,0, 2'd0, 0,0,0,0));
        vecs.push_back(mk(0,1,0,1,0,1, 2'd1, 1,0,1,0));
        // Counter cleared: D wins the next two ties, then I on its own
        vecs.push_back(mk(0,1,0,1,0,0, 2'd0, 0,0,0,0));
        vecs.push_back(mk(0,1,0,1,0,1, 2'd2, 1,0,0,1));
        vecs.push_back(mk(0,1,0,1,0,0, 2'd0, 0,0,0,0));
        vecs.push_back(mk(0,1,0,1,0,1, 2'd2, 1,0,0,1));
        vecs.push_back(mk(0,1,0,0,0,0, 2'd0, 0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,1, 2'd1, 1,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 2'd0, 0,0,0,0));
`endif
        // D-cache write, resp only when DDR responds
        vecs.push_back(mk(0,0,0,0,1,0, 2'd0, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0, 2'd2, 0,1,0,0));
        vecs.push_back(mk(0,0,0,0,1,0, 2'd2, 0,1,0,0));
        vecs.push_back(mk(0,0,0,0,1,1, 2'd2, 0,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,0, 2'd0, 0,0,0,0));
        // Reset two cycles into an I grant, then spurious DDR responses
        vecs.push_back(mk(0,1,0,0,0,0, 2'd0, 0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 2'd1, 1,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 2'd1, 1,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,0, 2'd0, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 2'd0, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 2'd0, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 2'd0, 0,0,0,0));

        rst              = 1'b1;
        icache_arb_addr  = I_ADDR;
        icache_arb_wdata = I_WDATA;
        dcache_arb_addr  = D_ADDR;
        dcache_arb_wdata = D_WDATA;
        ddr_arb_rdata    = RDATA;
        icache_arb_read  = 1'b0;
        icache_arb_write = 1'b0;
        dcache_arb_read  = 1'b0;
        dcache_arb_write = 1'b0;
        ddr_arb_resp     = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            rst              = vecs[i].rst;
            icache_arb_read  = vecs[i].ir;
            icache_arb_write = vecs[i].iw;
            dcache_arb_read  = vecs[i].dr;
            dcache_arb_write = vecs[i].dw;
            ddr_arb_resp     = vecs[i].resp;
            #1;
            check_row(vecs[i], i);
        end

        // Hand sequence: strobe latency from IDLE with a bounded wait
        @(negedge clk);
        dcache_arb_read = 1'b1;
        lat = 0;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk);
            lat++;
            if (arb_ddr_read) found = 1'b1;
        end
        chk("hs_strobe_latency", 100, 256'(lat), 256'd1);
        ddr_arb_resp = 1'b1;
        #1;
        chk("hs_d_resp", 101, {255'd0, arb_dcache_resp}, {255'd0, 1'b1});
        chk("hs_i_resp", 102, {255'd0, arb_icache_resp}, {255'd0, 1'b0});
        @(negedge clk);
        ddr_arb_resp    = 1'b0;
        dcache_arb_read = 1'b0;
        icache_arb_read = 1'b1;
        #1;
        chk("hs_bubble_read", 103, {255'd0, arb_ddr_read}, {255'd0, 1'b0});
        @(negedge clk);
        #1;
        chk("hs_i_granted", 104, {255'd0, arb_ddr_read}, {255'd0, 1'b1});

        // Hand sequence: reset raised mid-cycle drops the strobe at once
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("hs_async_rst_read", 105, {255'd0, arb_ddr_read}, {255'd0, 1'b0});
        chk("hs_async_rst_addr", 106, {224'd0, arb_ddr_addr}, 256'd0);
        @(negedge clk);
        rst             = 1'b0;
        icache_arb_read = 1'b0;
        #1;
        chk("hs_post_rst_read", 107, {255'd0, arb_ddr_read}, {255'd0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
